// File: rtl/cache_line_fill.sv
// Miss line-fill controller: fetches a whole cache line word by word into the victim way,
// then commits tag/valid and the replacement update. Option macro: CACHE_CRITICAL_WORD_FIRST_EN.
module cache_line_fill #(
    parameter int N_WAYS     = 8,
    parameter int NWAY_W     = $clog2(N_WAYS),
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_OFF_W = 7,
    parameter int WORD_OFF_W = 3,
    localparam int BYTE_W    = $clog2(DATA_W / 8),
    localparam int TAG_W     = ADDR_W - LINE_OFF_W - WORD_OFF_W - BYTE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    input  logic [N_WAYS-1:0]     way_select,
    input  logic [NWAY_W-1:0]     way_select_bin,
    output logic                  mem_valid,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [N_WAYS-1:0]     dmem_we,
    output logic [LINE_OFF_W-1:0] dmem_line,
    output logic [WORD_OFF_W-1:0] dmem_word,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [N_WAYS-1:0]     tag_we,
    output logic [TAG_W-1:0]      tag_wdata,
    output logic                  rp_write_en,
    output logic [N_WAYS-1:0]     rp_way_hit,
    output logic [DATA_W-1:0]     fe_rdata,
    output logic                  fe_rdata_valid,
    output logic                  busy,
    output logic                  fill_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [LINE_OFF_W-1:0] index_q, index_d;
    logic [WORD_OFF_W-1:0] req_off_q, req_off_d;
    logic [WORD_OFF_W-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_OFF_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [N_WAYS-1:0]     way_q, way_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  busy_q, busy_d;
    logic                  fill_done_q, fill_done_d;
    logic [N_WAYS-1:0]     tag_we_q, tag_we_d;
    logic [TAG_W-1:0]      tag_wdata_q, tag_wdata_d;
    logic                  rp_write_en_q, rp_write_en_d;
    logic [N_WAYS-1:0]     rp_way_hit_q, rp_way_hit_d;
    logic [DATA_W-1:0]     fe_rdata_q, fe_rdata_d;
    logic                  fe_rdata_valid_q, fe_rdata_valid_d;

    logic [N_WAYS-1:0]     way_dec;
    logic                  beat_accept;
    logic                  unused_byte_bits;

    // The binary victim backs up an all-zero one-hot so a fill always has a target way.
    assign way_dec          = N_WAYS'(1) << way_select_bin;
    assign unused_byte_bits = &{1'b0, miss_addr[BYTE_W-1:0]};

    // Handshake: mem_valid is held from accept until the last beat is taken; mem_ready is a
    // one-cycle response with mem_rdata valid in the same cycle, and each pulse consumes one word.
    assign beat_accept = mem_valid_q && mem_ready && !reset;

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        index_d          = index_q;
        req_off_d        = req_off_q;
        word_cnt_d       = word_cnt_q;
        beat_cnt_d       = beat_cnt_q;
        way_d            = way_q;
        fe_rdata_d       = fe_rdata_q;
        fe_rdata_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    tag_d      = miss_addr[ADDR_W-1 -: TAG_W];
                    index_d    = miss_addr[BYTE_W+WORD_OFF_W +: LINE_OFF_W];
                    req_off_d  = miss_addr[BYTE_W +: WORD_OFF_W];
                    way_d      = (|way_select) ? way_select : way_dec;
                    beat_cnt_d = '0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                    word_cnt_d = miss_addr[BYTE_W +: WORD_OFF_W];
`else
                    word_cnt_d = '0;
`endif
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    word_cnt_d = word_cnt_q + WORD_OFF_W'(1);
                    beat_cnt_d = beat_cnt_q + WORD_OFF_W'(1);
                    if (word_cnt_q == req_off_q) begin
                        fe_rdata_d       = mem_rdata;
                        fe_rdata_valid_d = 1'b1;
                    end
                    if (beat_cnt_q == {WORD_OFF_W{1'b1}}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_valid_d   = (state_d == FETCH);
        busy_d        = (state_d != IDLE);
        fill_done_d   = (state_d == DONE);
        tag_we_d      = (state_d == DONE) ? way_d : '0;
        tag_wdata_d   = (state_d == DONE) ? tag_d : '0;
        rp_write_en_d = (state_d == DONE);
        rp_way_hit_d  = (state_d == DONE) ? way_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            tag_q            <= '0;
            index_q          <= '0;
            req_off_q        <= '0;
            word_cnt_q       <= '0;
            beat_cnt_q       <= '0;
            way_q            <= '0;
            mem_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            fill_done_q      <= 1'b0;
            tag_we_q         <= '0;
            tag_wdata_q      <= '0;
            rp_write_en_q    <= 1'b0;
            rp_way_hit_q     <= '0;
            fe_rdata_q       <= '0;
            fe_rdata_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            tag_q            <= tag_d;
            index_q          <= index_d;
            req_off_q        <= req_off_d;
            word_cnt_q       <= word_cnt_d;
            beat_cnt_q       <= beat_cnt_d;
            way_q            <= way_d;
            mem_valid_q      <= mem_valid_d;
            busy_q           <= busy_d;
            fill_done_q      <= fill_done_d;
            tag_we_q         <= tag_we_d;
            tag_wdata_q      <= tag_wdata_d;
            rp_write_en_q    <= rp_write_en_d;
            rp_way_hit_q     <= rp_way_hit_d;
            fe_rdata_q       <= fe_rdata_d;
            fe_rdata_valid_q <= fe_rdata_valid_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_addr       = mem_valid_q ? {tag_q, index_q, word_cnt_q, {BYTE_W{1'b0}}} : '0;
    assign dmem_we        = beat_accept ? way_q : '0;
    assign dmem_wdata     = beat_accept ? mem_rdata : '0;
    assign dmem_line      = index_q;
    assign dmem_word      = word_cnt_q;
    assign tag_we         = tag_we_q;
    assign tag_wdata      = tag_wdata_q;
    assign rp_write_en    = rp_write_en_q;
    assign rp_way_hit     = rp_way_hit_q;
    assign fe_rdata       = fe_rdata_q;
    assign fe_rdata_valid = fe_rdata_valid_q;
    assign busy           = busy_q;
    assign fill_done      = fill_done_q;

endmodule

// File: tb/tb_cache_line_fill.sv
// Self-checking bench for cache_line_fill: back-end responder with random gaps, beat and
// completion scoreboard, reset abort and miss_req hold scenarios.
module tb_cache_line_fill;

    logic        clk;
    logic        reset;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic [7:0]  way_select;
    logic [2:0]  way_select_bin;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  dmem_we;
    logic [6:0]  dmem_line;
    logic [2:0]  dmem_word;
    logic [31:0] dmem_wdata;
    logic [7:0]  tag_we;
    logic [19:0] tag_wdata;
    logic        rp_write_en;
    logic [7:0]  rp_way_hit;
    logic [31:0] fe_rdata;
    logic        fe_rdata_valid;
    logic        busy;
    logic        fill_done;

    cache_line_fill dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .way_select(way_select), .way_select_bin(way_select_bin),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dmem_we(dmem_we), .dmem_line(dmem_line), .dmem_word(dmem_word), .dmem_wdata(dmem_wdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata), .rp_write_en(rp_write_en), .rp_way_hit(rp_way_hit),
        .fe_rdata(fe_rdata), .fe_rdata_valid(fe_rdata_valid), .busy(busy), .fill_done(fill_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_fe_q[$];
    logic [7:0]  exp_way;
    logic [19:0] exp_tag;
    logic [2:0]  exp_req_off;
    int          exp_fe_beat;
    int          fe_at_beat;
    int          beats_this_fill;
    int          done_cnt;
    int          exp_done_cnt;
    int          n_checks;
    int          n_errors;
    int          max_gap;
    bit          idle_toggle;
    bit          scramble;
    bit          fe_due;
    bit          prev_wait;
    logic [31:0] prev_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    // ---------------- back-end responder ----------------
    initial begin
        int gap_left;
        gap_left  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_valid) begin
                if (gap_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                    gap_left  = $urandom_range(0, max_gap);
                end else begin
                    gap_left--;
                    mem_rdata = $urandom;
                end
            end else if (idle_toggle) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [31:0] a;
        if (reset) begin
            fe_due    = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (fe_due || fe_rdata_valid) begin
                check("fe_valid_timing", 64'(fe_rdata_valid), 64'(fe_due));
                if (fe_rdata_valid) begin
                    fe_at_beat = beats_this_fill;
                    if (exp_fe_q.size() == 0) check("fe_unexpected", 1, 0);
                    else check("fe_rdata", fe_rdata, exp_fe_q.pop_front());
                end
            end
            fe_due = 1'b0;
            if (mem_valid && prev_wait) check("addr_stable", mem_addr, prev_addr);
            if (mem_valid && mem_ready) begin
                if (exp_addr_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    a = exp_addr_q.pop_front();
                    check("mem_addr", mem_addr, a);
                    check("dmem_we", dmem_we, exp_way);
                    check("dmem_word", dmem_word, a[4:2]);
                    check("dmem_line", dmem_line, a[11:5]);
                    check("dmem_wdata", dmem_wdata, mem_model(a));
                    if (a[4:2] == exp_req_off) fe_due = 1'b1;
                end
                beats_this_fill++;
            end else if (dmem_we != 0) begin
                check("dmem_we_no_beat", dmem_we, 0);
            end
            prev_wait = mem_valid && !mem_ready;
            prev_addr = mem_addr;
            if (fill_done || tag_we != 0 || rp_write_en) begin
                check("tag_we", tag_we, exp_way);
                check("tag_wdata", tag_wdata, exp_tag);
                check("rp_write_en", 64'(rp_write_en), 1);
                check("rp_way_hit", rp_way_hit, exp_way);
                check("fill_done", 64'(fill_done), 1);
                check("fill_beats", beats_this_fill, 8);
                check("busy_in_done", 64'(busy), 1);
                check("mem_valid_in_done", 64'(mem_valid), 0);
                beats_this_fill = 0;
                done_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [31:0] addr, input logic [2:0] wbin);
        logic [2:0] start;
        logic [2:0] w;
        exp_way     = 8'h1 << wbin;
        exp_tag     = addr[31:12];
        exp_req_off = addr[4:2];
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        start       = addr[4:2];
        exp_fe_beat = 1;
`else
        start       = 3'd0;
        exp_fe_beat = int'(addr[4:2]) + 1;
`endif
        for (int i = 0; i < 8; i++) begin
            w = start + 3'(i);
            exp_addr_q.push_back({addr[31:5], w, 2'b00});
        end
        exp_fe_q.push_back(mem_model({addr[31:5], addr[4:2], 2'b00}));
        fe_at_beat = -1;
    endtask

    task automatic start_fill(input logic [31:0] addr, input logic [2:0] wbin);
        @(posedge clk);
        #1;
        push_expect(addr, wbin);
        miss_addr      = addr;
        way_select     = 8'h1 << wbin;
        way_select_bin = wbin;
        miss_req       = 1'b1;
    endtask

    // Counts cycles with the request cycle as cycle 1; optionally keeps miss_req high.
    task automatic wait_done(input bit drop, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 1;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (scramble && busy) begin
                way_select     = 8'h1 << $urandom_range(0, 7);
                way_select_bin = 3'($urandom_range(0, 7));
            end
            if (fill_done) begin
                seen = 1'b1;
                if (drop) miss_req = 1'b0;
            end
        end
        if (!seen) begin
            check("fill_timeout", 1, 0);
            miss_req = 1'b0;
        end else begin
            exp_done_cnt++;
            check("fe_beat", fe_at_beat, exp_fe_beat);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_valid"}, 64'(mem_valid), 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_dmem_we"}, dmem_we, 0);
        check({tag, "_dmem_line"}, dmem_line, 0);
        check({tag, "_dmem_word"}, dmem_word, 0);
        check({tag, "_dmem_wdata"}, dmem_wdata, 0);
        check({tag, "_tag_we"}, tag_we, 0);
        check({tag, "_tag_wdata"}, tag_wdata, 0);
        check({tag, "_rp_write_en"}, 64'(rp_write_en), 0);
        check({tag, "_rp_way_hit"}, rp_way_hit, 0);
        check({tag, "_fe_rdata"}, fe_rdata, 0);
        check({tag, "_fe_rdata_valid"}, 64'(fe_rdata_valid), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_fill_done"}, 64'(fill_done), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        n_checks = 0; n_errors = 0; done_cnt = 0; exp_done_cnt = 0;
        beats_this_fill = 0; fe_at_beat = -1; exp_fe_beat = 0;
        exp_way = '0; exp_tag = '0; exp_req_off = '0;
        fe_due = 1'b0; prev_wait = 1'b0; prev_addr = '0;
        max_gap = 0; idle_toggle = 1'b0; scramble = 1'b0;
        reset = 1'b1; miss_req = 1'b0; miss_addr = '0; way_select = '0; way_select_bin = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_toggle = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_all_zero("idle");
        end
        @(posedge clk);
        #1;
        idle_toggle = 1'b0;

        // Reference miss, response every cycle.
        start_fill(32'h0000_1234, 3'd2);
        wait_done(1'b1, cyc);
        check("fill_latency", cyc, 10);

        // Random back-end gaps, victim changes mid-fill ignored.
        max_gap  = 5;
        scramble = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_fill($urandom, 3'($urandom_range(0, 7)));
            wait_done(1'b1, cyc);
        end
        scramble = 1'b0;
        max_gap  = 0;

        // Reset after the third beat aborts the fill without a commit.
        start_fill(32'h0000_1234, 3'd6);
        for (int n = 0; n < 100 && beats_this_fill < 3; n++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reached_beat3", 64'(beats_this_fill >= 3), 1);
        reset    = 1'b1;
        miss_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_addr_q.delete();
        exp_fe_q.delete();
        beats_this_fill = 0;
        check("abort_busy", 64'(busy), 0);
        check("abort_mem_valid", 64'(mem_valid), 0);
        repeat (4) begin
            @(negedge clk);
            check("abort_tag_we", tag_we, 0);
            check("abort_rp_write_en", 64'(rp_write_en), 0);
            check("abort_fill_done", 64'(fill_done), 0);
            check("abort_idle_busy", 64'(busy), 0);
        end
        start_fill(32'h0000_8a4c, 3'd1);
        wait_done(1'b1, cyc);
        check("post_abort_latency", cyc, 10);

        // miss_req held through the fill and dropped with fill_done: one fill only.
        start_fill(32'h0001_0310, 3'd7);
        wait_done(1'b1, cyc);
        repeat (4) @(posedge clk);
        #1;
        check("single_fill_busy", 64'(busy), 0);
        check("single_fill_mem_valid", 64'(mem_valid), 0);

        // miss_req held one cycle past fill_done: a second fill starts.
        start_fill(32'h0002_07f8, 3'd3);
        wait_done(1'b0, cyc);
        push_expect(32'h0002_07f8, 3'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("refill_busy", 64'(busy), 1);
        miss_req = 1'b0;
        wait_done(1'b1, cyc);

        repeat (3) @(posedge clk);
        #1;
        check("exp_addr_q_empty", exp_addr_q.size(), 0);
        check("exp_fe_q_empty", exp_fe_q.size(), 0);
        check("done_count", done_cnt, exp_done_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
